// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the tick/button/night sources and the phase controller.
// The controller sits on the slave side; the stimulus/host side is the master.
interface traffic_phase_ctrl_if #(
  parameter int CNT_W = 5
) ();
  logic             tick;
  logic             ped_req;
  logic             night;
  logic [2:0]       ns_light;
  logic [2:0]       ew_light;
  logic             walk;
  logic             ped_pending;
  logic [CNT_W-1:0] cnt_out;
  logic [2:0]       phase;

  modport master (
    output tick, ped_req, night,
    input  ns_light, ew_light, walk, ped_pending, cnt_out, phase
  );

  modport slave (
    input  tick, ped_req, night,
    output ns_light, ew_light, walk, ped_pending, cnt_out, phase
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller: NS/EW green-yellow-allred sequencing
// on one shared countdown, pedestrian green shortening and night flash mode.
module traffic_phase_ctrl #(
  parameter int pGREEN_TIME  = 14,
  parameter int pYELLOW_TIME = 2,
  parameter int pALLRED_TIME = 1,
  parameter int pPED_MIN     = 4,
  parameter int pCNT_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_ctrl_if.slave  bus
);

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED_1 = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] ALL_RED_2 = 3'd5;
  localparam logic [2:0] FLASH     = 3'd6;

  localparam logic [pCNT_WIDTH-1:0] LD_GREEN  = pCNT_WIDTH'(pGREEN_TIME);
  localparam logic [pCNT_WIDTH-1:0] LD_YELLOW = pCNT_WIDTH'(pYELLOW_TIME);
  localparam logic [pCNT_WIDTH-1:0] LD_ALLRED = pCNT_WIDTH'(pALLRED_TIME);
  localparam logic [pCNT_WIDTH-1:0] LD_PED    = pCNT_WIDTH'(pPED_MIN);

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  logic [2:0]            state_q, state_d;
  logic [pCNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  flash_q, flash_d;
  logic                  ped_q, ped_d;
  logic [2:0]            ns_lamp, ew_lamp;

  // Next state / count / flash; everything holds unless a tick arrives.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    if (bus.tick) begin
      if (state_q == FLASH) begin
        if (!bus.night) begin
          // Leave through a clearance so NS green always restarts cleanly.
          state_d = ALL_RED_2;
          cnt_d   = LD_ALLRED;
          flash_d = 1'b0;
        end else begin
          flash_d = ~flash_q;
          cnt_d   = '0;
        end
      end else if (state_q == 3'd7) begin
        // Illegal encoding: recover via clearance before NS green.
        state_d = ALL_RED_2;
        cnt_d   = LD_ALLRED;
      end else if (cnt_q == '0) begin
        case (state_q)
          NS_GREEN:  begin state_d = NS_YELLOW; cnt_d = LD_YELLOW; end
          NS_YELLOW: begin state_d = ALL_RED_1; cnt_d = LD_ALLRED; end
          EW_GREEN:  begin state_d = EW_YELLOW; cnt_d = LD_YELLOW; end
          EW_YELLOW: begin state_d = ALL_RED_2; cnt_d = LD_ALLRED; end
          ALL_RED_1: begin state_d = EW_GREEN;  cnt_d = LD_GREEN;  end
          default:   begin state_d = NS_GREEN;  cnt_d = LD_GREEN;  end
        endcase
        // Night request is only honoured once the junction is all-red.
        if ((state_q == ALL_RED_1 || state_q == ALL_RED_2) && bus.night) begin
          state_d = FLASH;
          cnt_d   = '0;
          flash_d = 1'b1;
        end
      end else if (state_q == NS_GREEN && ped_q && cnt_q > LD_PED) begin
        cnt_d = LD_PED;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Pedestrian latch: a fresh press wins over the clear on EW green entry.
  always_comb begin
    ped_d = ped_q;
    if (state_d == EW_GREEN && state_q != EW_GREEN)
      ped_d = 1'b0;
    if (bus.ped_req)
      ped_d = 1'b1;
  end

  // Controller registers; reset abandons the phase with no clearance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NS_GREEN;
      cnt_q   <= LD_GREEN;
      flash_q <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      ped_q   <= ped_d;
    end
  end

  // Lamp decode straight from registered state, no extra latency.
  always_comb begin
    ns_lamp = LAMP_R;
    ew_lamp = LAMP_R;
    case (state_q)
      NS_GREEN:  ns_lamp = LAMP_G;
      NS_YELLOW: ns_lamp = LAMP_Y;
      EW_GREEN:  ew_lamp = LAMP_G;
      EW_YELLOW: ew_lamp = LAMP_Y;
      FLASH: begin
        ns_lamp = flash_q ? LAMP_Y : LAMP_OFF;
        ew_lamp = flash_q ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign bus.ns_light    = ns_lamp;
  assign bus.ew_light    = ew_lamp;
  assign bus.walk        = (state_q == EW_GREEN);
  assign bus.ped_pending = ped_q;
  assign bus.cnt_out     = cnt_q;
  assign bus.phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: scenario tasks checked against a phase-table
// reference model of the intersection timing.
module tb_traffic_phase_ctrl;
  localparam int G = 14, Y = 2, A = 1, PMIN = 4, W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.CNT_W(W)) bus ();

  traffic_phase_ctrl #(
    .pGREEN_TIME(G), .pYELLOW_TIME(Y), .pALLRED_TIME(A),
    .pPED_MIN(PMIN), .pCNT_WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: phase index 0..5 around the ring, 6 = flashing.
  int m_ph, m_cnt;
  bit m_flash, m_ped;

  function automatic int load_of(int ph);
    case (ph % 3)
      0: return G;
      1: return Y;
      default: return A;
    endcase
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_cnt = G; m_flash = 0; m_ped = 0;
  endfunction

  function automatic void model_step(bit t, bit p, bit n);
    int prev = m_ph;
    if (t) begin
      if (m_ph == 6) begin
        if (!n) begin m_ph = 5; m_cnt = A; end
        else m_flash = !m_flash;
      end else if (m_cnt == 0) begin
        if ((m_ph == 2 || m_ph == 5) && n) begin
          m_ph = 6; m_cnt = 0; m_flash = 1;
        end else begin
          m_ph = (m_ph + 1) % 6; m_cnt = load_of(m_ph);
        end
      end else if (m_ph == 0 && m_ped && m_cnt > PMIN) m_cnt = PMIN;
      else m_cnt = m_cnt - 1;
    end
    if (m_ph == 3 && prev != 3) m_ped = 0;
    if (p) m_ped = 1;
  endfunction

  function automatic logic [15:0] exp_vec();
    logic [2:0] ns, ew;
    ns = 3'b100; ew = 3'b100;
    case (m_ph)
      0: ns = 3'b001;
      1: ns = 3'b010;
      3: ew = 3'b001;
      4: ew = 3'b010;
      6: begin ns = m_flash ? 3'b010 : 3'b000; ew = ns; end
      default: ;
    endcase
    return {ns, ew, (m_ph == 3), m_ped, W'(m_cnt), 3'(m_ph)};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {bus.ns_light, bus.ew_light, bus.walk, bus.ped_pending, bus.cnt_out, bus.phase};
  endfunction

  // One clock: drive inputs, advance model on the edge, settle past it.
  task automatic cycle(input bit t, input bit p, input bit n);
    bus.tick = t; bus.ped_req = p; bus.night = n;
    @(posedge clk);
    if (!rst) model_step(t, p, n);
    #1;
    bus.tick = 0; bus.ped_req = 0;
  endtask

  task automatic do_reset();
    bus.tick = 0; bus.ped_req = 0; bus.night = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  // Tick until the model reaches a phase, checking every step.
  task automatic run_to(input int ph, input bit n);
    int k = 0;
    while (m_ph != ph && k < 200) begin
      cycle(1, 0, n); k++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL run_to got %h exp %h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (m_ph != ph) begin
      n_fail++;
      $display("FAIL run_to_bound phase %0d never reached (model at %0d)", ph, m_ph);
    end
  endtask

  task automatic test_reset();
    rst = 1; bus.tick = 0; bus.ped_req = 0; bus.night = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_cmp++;
    if (obs_vec() !== {3'b001, 3'b100, 1'b0, 1'b0, W'(G), 3'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp %h", obs_vec(), {3'b001, 3'b100, 1'b0, 1'b0, W'(G), 3'd0});
    end
    rst = 0;
  endtask

  task automatic test_normal_cycle();
    int dur[6];
    int exp_dur[6];
    int ticks = 0, k = 0;
    bit t;
    do_reset();
    foreach (dur[i]) dur[i] = 0;
    exp_dur = '{G+1, Y+1, A+1, G+1, Y+1, A+1};
    while (ticks < 40 && k < 400) begin
      t = ($urandom_range(0, 2) != 0);
      if (t) begin
        if (bus.phase < 6) dur[bus.phase]++;
        ticks++;
      end
      cycle(t, 0, 0); k++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL normal_step got %h exp %h", obs_vec(), exp_vec());
      end
      n_cmp++;
      if (bus.ns_light != 3'b100 && bus.ew_light != 3'b100) begin
        n_fail++;
        $display("FAIL conflict ns %b ew %b", bus.ns_light, bus.ew_light);
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (dur[i] != exp_dur[i]) begin
        n_fail++;
        $display("FAIL duration phase %0d got %0d exp %0d", i, dur[i], exp_dur[i]);
      end
    end
    n_cmp++;
    if (bus.phase !== 3'd0 || bus.cnt_out !== W'(G)) begin
      n_fail++;
      $display("FAIL cycle_end phase %0d cnt %0d exp 0/%0d", bus.phase, bus.cnt_out, G);
    end
  endtask

  task automatic test_ped_shorten();
    do_reset();
    cycle(1, 0, 0); cycle(1, 0, 0);      // count 12
    cycle(0, 1, 0);                      // press without tick
    n_cmp++;
    if (bus.ped_pending !== 1'b1 || bus.cnt_out !== W'(12)) begin
      n_fail++;
      $display("FAIL ped_latch pend %b cnt %0d exp 1/12", bus.ped_pending, bus.cnt_out);
    end
    cycle(1, 0, 0);
    n_cmp++;
    if (bus.cnt_out !== W'(PMIN)) begin
      n_fail++;
      $display("FAIL ped_load cnt %0d exp %0d", bus.cnt_out, PMIN);
    end
    repeat (PMIN) cycle(1, 0, 0);
    n_cmp++;
    if (bus.phase !== 3'd0 || bus.cnt_out !== 5'd0) begin
      n_fail++;
      $display("FAIL ped_hold phase %0d cnt %0d exp 0/0", bus.phase, bus.cnt_out);
    end
    cycle(1, 0, 0);
    n_cmp++;
    if (bus.phase !== 3'd1) begin
      n_fail++;
      $display("FAIL ped_green_end phase %0d exp 1", bus.phase);
    end
    run_to(3, 0);
    n_cmp++;
    if (bus.walk !== 1'b1 || bus.ped_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL ped_walk walk %b pend %b exp 1/0", bus.walk, bus.ped_pending);
    end
    // Press on the same edge as a tick: no shortening until the next tick.
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    n_cmp++;
    if (bus.cnt_out !== W'(12)) begin
      n_fail++;
      $display("FAIL ped_same_edge cnt %0d exp 12", bus.cnt_out);
    end
    cycle(1, 0, 0);
    n_cmp++;
    if (bus.cnt_out !== W'(PMIN)) begin
      n_fail++;
      $display("FAIL ped_next_tick cnt %0d exp %0d", bus.cnt_out, PMIN);
    end
  endtask

  task automatic test_ped_late();
    do_reset();
    repeat (G - 3) cycle(1, 0, 0);       // count 3
    cycle(0, 1, 0);
    for (int i = 2; i >= 0; i--) begin
      cycle(1, 0, 0);
      n_cmp++;
      if (bus.cnt_out !== W'(i) || bus.phase !== 3'd0) begin
        n_fail++;
        $display("FAIL ped_late cnt %0d phase %0d exp %0d/0", bus.cnt_out, bus.phase, i);
      end
    end
    run_to(3, 0);
    cycle(0, 1, 0);                      // press during EW green
    run_to(0, 0);
    n_cmp++;
    if (bus.ped_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL ped_keep pend %b exp 1", bus.ped_pending);
    end
    run_to(3, 0);
    n_cmp++;
    if (bus.ped_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL ped_clear pend %b exp 0", bus.ped_pending);
    end
  endtask

  task automatic test_night();
    do_reset();
    run_to(3, 0);
    run_to(6, 1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL flash got %h exp %h", obs_vec(), exp_vec());
      end
      cycle(1, 0, 1);
    end
    cycle(1, 0, 0);
    n_cmp++;
    if (bus.phase !== 3'd5 || bus.cnt_out !== W'(A)) begin
      n_fail++;
      $display("FAIL night_exit phase %0d cnt %0d exp 5/%0d", bus.phase, bus.cnt_out, A);
    end
    repeat (A + 1) cycle(1, 0, 0);
    n_cmp++;
    if (bus.phase !== 3'd0 || bus.cnt_out !== W'(G)) begin
      n_fail++;
      $display("FAIL night_resume phase %0d cnt %0d exp 0/%0d", bus.phase, bus.cnt_out, G);
    end
  endtask

  task automatic test_back_to_back();
    int changes = 0;
    logic [2:0] prev;
    do_reset();
    bus.tick = 1;
    for (int i = 0; i < 40; i++) begin
      prev = bus.phase;
      bus.tick = 1; bus.ped_req = 0; bus.night = 0;
      @(posedge clk); model_step(1, 0, 0); #1;
      if (bus.phase !== prev) changes++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b got %h exp %h", obs_vec(), exp_vec());
      end
    end
    bus.tick = 0;
    n_cmp++;
    if (changes != 6 || bus.phase !== 3'd0 || bus.cnt_out !== W'(G)) begin
      n_fail++;
      $display("FAIL b2b_cycle changes %0d phase %0d cnt %0d exp 6/0/%0d", changes, bus.phase, bus.cnt_out, G);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    run_to(4, 0);
    cycle(1, 0, 0);
    #3 rst = 1;
    #1;
    n_cmp++;
    if (obs_vec() !== {3'b001, 3'b100, 1'b0, 1'b0, W'(G), 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset got %h exp %h", obs_vec(), {3'b001, 3'b100, 1'b0, 1'b0, W'(G), 3'd0});
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    repeat (G + 1) cycle(1, 0, 0);
    n_cmp++;
    if (bus.phase !== 3'd1 || bus.cnt_out !== W'(Y)) begin
      n_fail++;
      $display("FAIL post_reset phase %0d cnt %0d exp 1/%0d", bus.phase, bus.cnt_out, Y);
    end
  endtask

  task automatic test_random();
    bit n = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) n = !n;
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0, n);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random step %0d got %h exp %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.tick = 0; bus.ped_req = 0; bus.night = 0;
    test_reset();
    test_normal_cycle();
    test_ped_shorten();
    test_ped_late();
    test_night();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Two-road intersection phase controller. Sequences the main (NS) and side (EW) signal heads through green, yellow and all-red clearance using one shared countdown, with a pedestrian shortening request and a night flashing mode. Sits between the 1 Hz tick generator and the lamp drivers and display. Its countdown keeps the same semantics as the existing light counter: load a phase value, decrement per tick, and expire at 0.

## Interface
- pGREEN_TIME, 14: green phase load value; the phase lasts pGREEN_TIME+1 ticks.
- pYELLOW_TIME, 2: yellow phase load value.
- pALLRED_TIME, 1: all-red clearance load value.
- pPED_MIN, 4: green remaining-count floor applied on a pedestrian request; must be < pGREEN_TIME.
- pCNT_WIDTH, 5: countdown width; must hold the largest load value.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle time strobe; nothing advances without it.
- ped_req  in  1  pedestrian button pulse, any length; latched.
- night  in  1  night-mode request level.
- ns_light  out  3  one-hot {R,Y,G}, bit0 = G.
- ew_light  out  3  one-hot {R,Y,G}, bit0 = G.
- walk  out  1  high while pedestrians may cross NS (state EW_GREEN).
- ped_pending  out  1  latched pedestrian request.
- cnt_out  out  pCNT_WIDTH  remaining count of the current phase.
- phase  out  3  state encoding, for debug and display.

## Operation
- States and encodings: NS_GREEN=0, NS_YELLOW=1, ALL_RED_1=2, EW_GREEN=3, EW_YELLOW=4, ALL_RED_2=5, FLASH=6. Encoding 7 is illegal; from 7, go to ALL_RED_2 with count pALLRED_TIME.
- Normal cycle: NS_GREEN → NS_YELLOW → ALL_RED_1 → EW_GREEN → EW_YELLOW → ALL_RED_2 → NS_GREEN.
- Load values on entry:
  - Green states load pGREEN_TIME.
  - Yellow states load pYELLOW_TIME.
  - All-red states load pALLRED_TIME.
- On a tick with count==0, move to the next state and load its value.
- On a tick with count!=0, decrement the count.
- Pedestrian shortening: on a tick in NS_GREEN with ped_pending=1 and count>pPED_MIN, load pPED_MIN instead of decrementing. Otherwise apply the normal rule.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge that enters EW_GREEN.
  - If both happen on the same edge, set wins.
- Night mode:
  - Checked only at all-red expiry. On a tick in ALL_RED_1 or ALL_RED_2 with count==0 and night=1, go to FLASH instead of the next green.
  - In FLASH, an internal flash bit toggles on every tick. Both heads show Y when flash=1 and all lamps off (3'b000) when flash=0. cnt_out holds 0.
  - Entering FLASH sets flash=1.
  - On a tick in FLASH with night=0, go to ALL_RED_2 and load pALLRED_TIME. This always resumes at NS_GREEN.
- Light decode (pure function of the registered state):
  - NS_GREEN: ns=G, ew=R.
  - NS_YELLOW: ns=Y, ew=R.
  - EW_GREEN: ns=R, ew=G.
  - EW_YELLOW: ns=R, ew=Y.
  - ALL_RED_x: both R.
- Wrap-around: the count never decrements below 0, because expiry always reloads.

## Timing
- Reset (async assert) forces:
  - state=NS_GREEN, count=pGREEN_TIME, ped_pending=0, flash=0.
  - Outputs: ns_light=3'b001, ew_light=3'b100, walk=0, cnt_out=pGREEN_TIME, phase=0.
- Reset mid-phase abandons the phase immediately, with no clearance interval. Release is synchronous to the next edge.
- State, count and flash update only on edges where tick=1. The lights change on the same edge as the state, with zero added latency (decode of registered state).
- ped_pending updates on every edge, independent of tick. A ped_req sampled on the same edge as a shortening tick does not shorten on that edge; the shortening takes effect from the next tick.
- Phase durations in ticks:
  - Green: pGREEN_TIME+1, default 15.
  - Yellow: pYELLOW_TIME+1, default 3.
  - All-red: pALLRED_TIME+1, default 2.
- Full normal cycle: 40 ticks.
- Consecutive ticks on back-to-back cycles must be handled correctly (tick=1 held high is legal).

## Test plan
- Reset, then 40 ticks, night=0, no ped → phases 0,1,2,3,4,5,0. Lasts 15/3/2/15/3/2 ticks. The lights are never both non-red.
- ped_req pulse while in NS_GREEN at count 12 → next tick loads 4. Green ends 5 ticks later. walk=1 in EW_GREEN and ped_pending clears on entry.
- ped_req at NS_GREEN count 3 → no reload, green ends naturally. ped_req during EW_GREEN → ped_pending stays 1 until the next EW_GREEN entry.
- night=1 raised during EW_GREEN → phases EW_YELLOW, ALL_RED_2, then FLASH. Both heads alternate Y/off each tick. night=0 → ALL_RED_2 for 2 ticks, then NS_GREEN with count 14.
- tick held high continuously → one state step per cycle, and a full cycle takes 40 clocks.
- rst asserted mid-EW_YELLOW, between clock edges → outputs reach reset values immediately. Release, then 15 ticks → NS_YELLOW.
